// File: rtl/lcd_bus_reader.sv
// Read-cycle controller for an HD44780-style character LCD on the 8-bit bus.
// Performs single RW=1 reads (busy flag + address counter, or data RAM) and can
// poll the busy flag until it clears, bounded by a retry limit. While a read is
// in flight it claims RS/RW/E through o_bus_own so the write path backs off.
module lcd_bus_reader #(
    parameter int unsigned SETUP_CLKS = 3,    // RS/RW stable to E rise, >= 1
    parameter int unsigned E_HI_CLKS  = 25,   // E high time, >= 2
    parameter int unsigned E_LO_CLKS  = 25,   // E low / hold time, >= 1
    parameter int unsigned MAX_POLLS  = 4096  // busy-flag reads before timeout, >= 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [7:0] i_db,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_e,
    output logic       o_bus_own,
    output logic       o_busy,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_bf,
    output logic [6:0] o_ac,
    output logic       o_timeout
);

    localparam int unsigned DLY_MAX_AB = (SETUP_CLKS > E_HI_CLKS) ? SETUP_CLKS : E_HI_CLKS;
    localparam int unsigned DLY_MAX    = (DLY_MAX_AB > E_LO_CLKS) ? DLY_MAX_AB : E_LO_CLKS;
    // The delay counter only ever holds N-1, so clog2(max) bits are enough
    localparam int unsigned DW = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int unsigned PW = $clog2(MAX_POLLS + 1);

    localparam logic [DW-1:0] SETUP_LAST = DW'(SETUP_CLKS - 1);
    localparam logic [DW-1:0] EHI_LAST   = DW'(E_HI_CLKS - 1);
    localparam logic [DW-1:0] ELO_LAST   = DW'(E_LO_CLKS - 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

    typedef enum logic [2:0] {
        StIdle,
        StAddrSetup,
        StEHi,
        StELo,
        StDone
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dly_cnt_q;
    logic [PW-1:0] poll_cnt_q;
    logic          poll_q;

    // Read sequencer: state, counters and every registered bus/status output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            dly_cnt_q  <= '0;
            poll_cnt_q <= '0;
            poll_q     <= 1'b0;
            o_rs       <= 1'b0;
            o_rw       <= 1'b0;
            o_e        <= 1'b0;
            o_bus_own  <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_timeout  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_req) begin
                        state_q    <= StAddrSetup;
                        dly_cnt_q  <= '0;
                        poll_cnt_q <= '0;
                        // Polling only makes sense on the busy-flag register
                        poll_q     <= i_poll & ~i_rs;
                        o_rs       <= i_rs;
                        o_rw       <= 1'b1;
                        o_bus_own  <= 1'b1;
                        o_busy     <= 1'b1;
                        o_timeout  <= 1'b0;
                    end
                end
                StAddrSetup: begin
                    if (dly_cnt_q == SETUP_LAST) begin
                        state_q   <= StEHi;
                        dly_cnt_q <= '0;
                        o_e       <= 1'b1;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                StEHi: begin
                    if (dly_cnt_q == EHI_LAST) begin
                        // Bus is sampled on the last E-high cycle, i.e. as E falls
                        state_q    <= StELo;
                        dly_cnt_q  <= '0;
                        o_e        <= 1'b0;
                        o_data     <= i_db;
                        poll_cnt_q <= poll_cnt_q + 1'b1;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                StELo: begin
                    if (dly_cnt_q == ELO_LAST) begin
                        dly_cnt_q <= '0;
                        if (poll_q && o_data[7] && (poll_cnt_q < POLL_LIMIT)) begin
                            state_q <= StAddrSetup;
                        end else begin
                            state_q   <= StDone;
                            o_valid   <= 1'b1;
                            o_rs      <= 1'b0;
                            o_rw      <= 1'b0;
                            o_bus_own <= 1'b0;
                            // Still busy after the last permitted read means timeout
                            o_timeout <= poll_q & o_data[7];
                        end
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Busy-flag / address-counter views of the last sampled byte
    always_comb begin
        o_bf = o_data[7];
        o_ac = o_data[6:0];
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader. Instance 0 uses the default timing;
// instance 1 uses minimal timing with MAX_POLLS=4 so poll limits are reachable.
// Expected results come from a transaction-level model: number of reads,
// latency, pulse count and returned byte are derived from the read rules.
module tb_lcd_bus_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0]      req, rs, poll;
    logic [1:0][7:0] db;
    logic [1:0]      rs_o, rw, e, own, busy, valid, bf, tmo;
    logic [1:0][7:0] data;
    logic [1:0][6:0] ac;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    lcd_bus_reader u_dut0 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req[0]),
        .i_rs     (rs[0]),
        .i_poll   (poll[0]),
        .i_db     (db[0]),
        .o_rs     (rs_o[0]),
        .o_rw     (rw[0]),
        .o_e      (e[0]),
        .o_bus_own(own[0]),
        .o_busy   (busy[0]),
        .o_valid  (valid[0]),
        .o_data   (data[0]),
        .o_bf     (bf[0]),
        .o_ac     (ac[0]),
        .o_timeout(tmo[0])
    );

    lcd_bus_reader #(
        .SETUP_CLKS(1),
        .E_HI_CLKS (2),
        .E_LO_CLKS (1),
        .MAX_POLLS (4)
    ) u_dut1 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req[1]),
        .i_rs     (rs[1]),
        .i_poll   (poll[1]),
        .i_db     (db[1]),
        .o_rs     (rs_o[1]),
        .o_rw     (rw[1]),
        .o_e      (e[1]),
        .o_bus_own(own[1]),
        .o_busy   (busy[1]),
        .o_valid  (valid[1]),
        .o_data   (data[1]),
        .o_bf     (bf[1]),
        .o_ac     (ac[1]),
        .o_timeout(tmo[1])
    );

    function automatic int unsigned s_of(input int unsigned d);
        return (d == 0) ? 3 : 1;
    endfunction
    function automatic int unsigned h_of(input int unsigned d);
        return (d == 0) ? 25 : 2;
    endfunction
    function automatic int unsigned l_of(input int unsigned d);
        return (d == 0) ? 25 : 1;
    endfunction
    function automatic int unsigned m_of(input int unsigned d);
        return (d == 0) ? 4096 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One complete transaction; dv[k] is the bus value for read k (last repeats)
    task automatic run_txn(input int unsigned d, input logic r, input logic p,
                           input int unsigned n, input logic [31:0] dvw, input string nm);
        logic [3:0][7:0] dv;
        int unsigned reads, exp_lat, cyc, pulses, first_rise, hi_len, bad_w, bad_rw;
        int unsigned idx, budget;
        logic exp_to, got_v, prev_e;
        logic [7:0] exp_d, v;
        dv = dvw;
        // Model: count reads until the flag clears, polling disabled, or limit reached
        reads  = 0;
        exp_to = 1'b0;
        v      = 8'h00;
        while (1) begin
            v = dv[(reads < n) ? reads : n - 1];
            reads++;
            if (!(p && !r) || !v[7]) break;
            if (reads == m_of(d)) begin
                exp_to = 1'b1;
                break;
            end
        end
        exp_d   = v;
        exp_lat = reads * (s_of(d) + h_of(d) + l_of(d));

        db[d]   = dv[0];
        rs[d]   = r;
        poll[d] = p;
        req[d]  = 1'b1;
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        chk({nm, ".acc_busy"}, busy[d], 1);
        chk({nm, ".acc_rw"}, rw[d], 1);
        chk({nm, ".acc_rs"}, rs_o[d], r);
        chk({nm, ".acc_own"}, own[d], 1);
        chk({nm, ".acc_tmo"}, tmo[d], 0);

        idx = 0; pulses = 0; first_rise = 0; hi_len = 0; bad_w = 0; bad_rw = 0;
        got_v = 1'b0; prev_e = e[d]; cyc = 0;
        budget = exp_lat + 20;
        for (int c = 1; c <= int'(budget); c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (e[d] && !prev_e) begin
                pulses++;
                if (pulses == 1) first_rise = cyc;
                hi_len = 0;
            end
            if (e[d]) hi_len++;
            if (!e[d] && prev_e) begin
                if (hi_len != h_of(d)) bad_w++;
                idx++;
                db[d] = dv[(idx < n) ? idx : n - 1];
            end
            prev_e = e[d];
            if (valid[d]) begin
                got_v = 1'b1;
                break;
            end
            if (rw[d] !== 1'b1 || rs_o[d] !== r || own[d] !== 1'b1 || busy[d] !== 1'b1)
                bad_rw++;
        end
        chk({nm, ".valid_seen"}, got_v, 1);
        chk({nm, ".latency"}, cyc, exp_lat);
        chk({nm, ".pulses"}, pulses, reads);
        chk({nm, ".e_rise"}, first_rise, s_of(d));
        chk({nm, ".e_width_bad"}, bad_w, 0);
        chk({nm, ".bus_hold_bad"}, bad_rw, 0);
        chk({nm, ".data"}, data[d], exp_d);
        chk({nm, ".bf"}, bf[d], exp_d[7]);
        chk({nm, ".ac"}, ac[d], exp_d[6:0]);
        chk({nm, ".timeout"}, tmo[d], exp_to);
        chk({nm, ".done_own"}, own[d], 0);
        chk({nm, ".done_rw"}, rw[d], 0);
        chk({nm, ".done_e"}, e[d], 0);
        chk({nm, ".done_busy"}, busy[d], 1);
        @(posedge clk);
        #1;
        chk({nm, ".idle_valid"}, valid[d], 0);
        chk({nm, ".idle_busy"}, busy[d], 0);
        chk({nm, ".hold_data"}, data[d], exp_d);
        chk({nm, ".hold_tmo"}, tmo[d], exp_to);
        poll[d] = 1'b0;
    endtask

    typedef struct {
        int unsigned dut;
        logic        rs;
        logic        poll;
        int unsigned n;
        logic [31:0] dbw;   // byte k = read k
        string       nm;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int unsigned k, vcnt, pcnt, first_v;
        logic seen_v, prev, busy5, busy6, rw6;
        logic [31:0] rv;
        int unsigned rn;

        tbl[0] = '{0, 1'b1, 1'b0, 1, 32'h0000_0041, "ram_41"};
        tbl[1] = '{0, 1'b0, 1'b0, 1, 32'h0000_00A5, "bfac_a5"};
        tbl[2] = '{0, 1'b0, 1'b1, 4, 32'h1280_8080, "poll_clear"};
        tbl[3] = '{0, 1'b1, 1'b1, 2, 32'h0000_1280, "poll_rs1"};
        tbl[4] = '{1, 1'b0, 1'b1, 4, 32'hFFFF_FFFF, "poll_tmo"};
        tbl[5] = '{1, 1'b0, 1'b1, 4, 32'h7F80_8080, "poll_last"};
        tbl[6] = '{1, 1'b0, 1'b1, 1, 32'h0000_0005, "poll_first"};

        rst_n = 1'b0;
        req = '0; rs = '0; poll = '0; db = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst.rs", rs_o[d], 0);
            chk("rst.rw", rw[d], 0);
            chk("rst.e", e[d], 0);
            chk("rst.own", own[d], 0);
            chk("rst.busy", busy[d], 0);
            chk("rst.valid", valid[d], 0);
            chk("rst.data", data[d], 0);
            chk("rst.tmo", tmo[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i])
            run_txn(tbl[i].dut, tbl[i].rs, tbl[i].poll, tbl[i].n, tbl[i].dbw, tbl[i].nm);

        // Random transactions on the fast instance
        for (int t = 0; t < 24; t++) begin
            rn = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) begin
                rv[j*8 +: 8] = 8'($urandom);
                if (j < int'(rn) - 1 && $urandom_range(0, 3) != 0) rv[j*8 + 7] = 1'b1;
            end
            run_txn(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rn, rv,
                    $sformatf("rnd%0d", t));
        end

        // Request held high through the whole transaction and DONE
        db[1] = 8'h33; rs[1] = 1'b1; poll[1] = 1'b0; req[1] = 1'b1;
        @(posedge clk);
        #1;
        vcnt = 0; pcnt = 0; first_v = 0; prev = e[1];
        busy5 = 1'b1; busy6 = 1'b0; rw6 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (e[1] && !prev) pcnt++;
            prev = e[1];
            if (valid[1]) begin
                vcnt++;
                if (first_v == 0) first_v = c;
            end
            if (c == 5) busy5 = busy[1];
            if (c == 6) begin
                busy6 = busy[1];
                rw6   = rw[1];
            end
        end
        req[1] = 1'b0;
        chk("hold.first_valid", first_v, 4);
        chk("hold.valid_cnt", vcnt, 1);
        chk("hold.pulses", pcnt, 1);
        chk("hold.busy_low", busy5, 0);
        chk("hold.restart_busy", busy6, 1);
        chk("hold.restart_rw", rw6, 1);
        k = 0; seen_v = 1'b0;
        while (!seen_v && k < 20) begin
            @(posedge clk);
            #1;
            seen_v = valid[1];
            k++;
        end
        chk("hold.second_done", seen_v, 1);
        chk("hold.second_data", data[1], 8'h33);
        @(posedge clk);
        #1;

        // Asynchronous reset while E is high
        db[0] = 8'h5A; rs[0] = 1'b1; poll[0] = 1'b0; req[0] = 1'b1;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        k = 0;
        while (!e[0] && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("arst.e_seen", e[0], 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.e", e[0], 0);
        chk("arst.rw", rw[0], 0);
        chk("arst.own", own[0], 0);
        chk("arst.busy", busy[0], 0);
        chk("arst.data", data[0], 0);
        seen_v = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen_v = seen_v | valid[0];
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            seen_v = seen_v | valid[0] | busy[0];
        end
        chk("arst.no_valid", seen_v, 0);
        run_txn(0, 1'b1, 1'b0, 1, 32'h0000_0041, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
